sync_filter_bank: RTL and testbench

SYNC_FILTER_BANK -- requirements
Module: sync_filter_bank

---
 rtl/sync_filter_bank.sv | 75 +++++++
 tb/tb_sync_filter_bank.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sync_filter_bank.sv
// sync_filter_bank: per-channel synchroniser plus stability filter with registered edge pulses.

module falsepath_anchor (
   input  logic a,
   output logic y
);
   assign y = a;
endmodule

module sync_filter_bank #(
   parameter int             W             = 4,
   parameter int             SYNC_STAGES   = 2,
   parameter int             FILTER_CYCLES = 4,
   parameter logic [W-1:0]   RESET_VAL     = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i,
   input  logic         hold,
   output logic [W-1:0] o,
   output logic [W-1:0] rise,
   output logic [W-1:0] fall
);
   localparam int CW = $clog2(FILTER_CYCLES + 1);
   localparam logic [CW-1:0] CMAX = CW'(FILTER_CYCLES - 1);

   logic [W-1:0]  i_a;
   logic [W-1:0]  sync [SYNC_STAGES];
   logic [W-1:0]  s;
   logic [W-1:0]  o_nxt;
   logic [CW-1:0] cnt [W];
   logic [CW-1:0] cnt_nxt [W];

   // every raw input bit crosses through a named cell so timing tools can cut the path
   genvar n;
   for (n = 0; n < W; n++) begin : g_anchor
      falsepath_anchor u_anchor (.a(i[n]), .y(i_a[n]));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync[k] <= RESET_VAL;
      end else begin
         sync[0] <= i_a;
         for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
      end
   end

   assign s = sync[SYNC_STAGES-1];

   always_comb begin
      o_nxt = o;
      for (int k = 0; k < W; k++) begin
         cnt_nxt[k] = '0;
         if (!hold && (s[k] != o[k])) begin
            if (cnt[k] == CMAX) o_nxt[k] = s[k];
            else                cnt_nxt[k] = cnt[k] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o    <= RESET_VAL;
         rise <= '0;
         fall <= '0;
         cnt  <= '{default: '0};
      end else begin
         o    <= o_nxt;
         rise <= o_nxt & ~o;
         fall <= o & ~o_nxt;
         cnt  <= cnt_nxt;
      end
   end
endmodule

// File: tb/tb_sync_filter_bank.sv
// tb_sync_filter_bank: directed checks of synchroniser latency, glitch rejection, hold and reset.

module tb_sync_filter_bank;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] i = 4'hF;
   logic       hold = 1'b0;
   logic [3:0] o, rise, fall;
   int         total = 0;
   int         failed = 0;

   sync_filter_bank #(.W(4), .SYNC_STAGES(2), .FILTER_CYCLES(4), .RESET_VAL(4'h0)) dut (
      .clk(clk), .rst_n(rst_n), .i(i), .hold(hold), .o(o), .rise(rise), .fall(fall)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset with all inputs high
      step(2);
      chk("rst_o", o, 4'h0);
      chk("rst_rise", rise, 4'h0);
      chk("rst_fall", fall, 4'h0);
      rst_n = 1'b1;
      step(1);
      chk("post_rst_o", o, 4'h0);
      chk("post_rst_rise", rise, 4'h0);
      step(4);
      chk("rst_exit_o5", o, 4'h0);
      step(1);
      chk("rst_exit_o6", o, 4'hF);
      chk("rst_exit_rise6", rise, 4'hF);
      step(1);
      chk("rst_exit_rise7", rise, 4'h0);
      chk("rst_exit_o7", o, 4'hF);
      // all channels fall
      i = 4'h0;
      step(5);
      chk("all_fall_o5", o, 4'hF);
      step(1);
      chk("all_fall_o6", o, 4'h0);
      chk("all_fall_fall6", fall, 4'hF);
      step(1);
      chk("all_fall_fall7", fall, 4'h0);
      // single channel rise on i[0]
      i = 4'h1;
      step(5);
      chk("ch0_o5", o, 4'h0);
      step(1);
      chk("ch0_o6", o, 4'h1);
      chk("ch0_rise6", rise, 4'h1);
      chk("ch0_fall6", fall, 4'h0);
      step(1);
      chk("ch0_rise7", rise, 4'h0);
      chk("ch0_o7", o, 4'h1);
      // 3-cycle glitch on i[1] is rejected
      i = 4'h3;
      step(3);
      i = 4'h1;
      for (int k = 0; k < 10; k++) begin
         step(1);
         chk("glitch3_o", o, 4'h1);
         chk("glitch3_rise", rise, 4'h0);
         chk("glitch3_fall", fall, 4'h0);
      end
      // 4-cycle pulse on i[1] passes for 4 cycles
      i = 4'h3;
      step(4);
      i = 4'h1;
      step(1);
      chk("pulse4_o5", o, 4'h1);
      step(1);
      chk("pulse4_o6", o, 4'h3);
      chk("pulse4_rise6", rise, 4'h2);
      step(3);
      chk("pulse4_o9", o, 4'h3);
      chk("pulse4_rise9", rise, 4'h0);
      step(1);
      chk("pulse4_o10", o, 4'h1);
      chk("pulse4_fall10", fall, 4'h2);
      step(1);
      chk("pulse4_fall11", fall, 4'h0);
      // hold freezes o while i[2] rises
      hold = 1'b1;
      i = 4'h5;
      for (int k = 0; k < 10; k++) begin
         step(1);
         chk("hold_o", o, 4'h1);
         chk("hold_rise", rise, 4'h0);
      end
      hold = 1'b0;
      step(3);
      chk("unhold_o3", o, 4'h1);
      step(1);
      chk("unhold_o4", o, 4'h5);
      chk("unhold_rise4", rise, 4'h4);
      step(1);
      chk("unhold_rise5", rise, 4'h0);
      // reset in the middle of a count on i[3]
      i = 4'hD;
      step(4);
      rst_n = 1'b0;
      step(1);
      chk("midrst_o", o, 4'h0);
      chk("midrst_rise", rise, 4'h0);
      chk("midrst_fall", fall, 4'h0);
      step(1);
      rst_n = 1'b1;
      step(5);
      chk("rerst_o5", o, 4'h0);
      chk("rerst_rise5", rise, 4'h0);
      step(1);
      chk("rerst_o6", o, 4'hD);
      chk("rerst_rise6", rise, 4'hD);
      step(1);
      chk("rerst_rise7", rise, 4'h0);
      // settle o[2]=0, o[3]=1 then swap both on the same edge
      i = 4'h9;
      step(6);
      chk("prep_o", o, 4'h9);
      chk("prep_fall", fall, 4'h4);
      step(1);
      i = 4'h5;
      step(5);
      chk("swap_o5", o, 4'h9);
      step(1);
      chk("swap_o6", o, 4'h5);
      chk("swap_rise6", rise, 4'h4);
      chk("swap_fall6", fall, 4'h8);
      step(1);
      chk("swap_rise7", rise, 4'h0);
      chk("swap_fall7", fall, 4'h0);
      $display("%0d/%0d checks passed", total - failed, total);
      $finish;
   end
endmodule
